// File: rtl/alzette_pkg.sv
// Shared definitions for the multi-cycle Alzette ISE unit: opcodes, round
// constants, per-step rotation amounts and FSM encoding.
package alzette_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ENC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_GETY = 2'd3
  } op_t;

  localparam logic [1:0] CUSTOM_2 = 2'd2;
  localparam logic [3:0] FN_ENC   = 4'b1100;
  localparam logic [3:0] FN_DEC   = 4'b1101;
  localparam logic [3:0] FN_GETY  = 4'b1110;

  localparam logic [31:0] RCON [0:7] = '{
    32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
    32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D
  };

  // Rotate-right amounts for step s0..s3
  localparam logic [4:0] R1 [0:3] = '{5'd31, 5'd17, 5'd0, 5'd24};
  localparam logic [4:0] R2 [0:3] = '{5'd24, 5'd17, 5'd31, 5'd16};

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
  endfunction

  function automatic op_t decode_op(input logic [1:0] fn, input logic [3:0] funct,
                                    input logic dec_en);
    op_t op;
    op = OP_NONE;
    if (fn == CUSTOM_2) begin
      case (funct)
        FN_ENC:  op = OP_ENC;
        FN_DEC:  op = dec_en ? OP_DEC : OP_NONE;
        FN_GETY: op = OP_GETY;
        default: op = OP_NONE;
      endcase
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/alzette_step.sv
// One combinational Alzette step, forward (encrypt) or inverse (decrypt),
// with rotation amounts picked by the step index.
module alzette_step
  import alzette_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] c,
  input  logic [1:0]  idx,
  input  logic        dec,
  output logic [31:0] x_next,
  output logic [31:0] y_next
);

  logic [31:0] x1_s;
  logic [31:0] y1_s;
  logic [4:0]  r1_s;
  logic [4:0]  r2_s;

  // Single ARX step; the inverse undoes the forward operations in reverse order
  always_comb begin
    r1_s = R1[idx];
    r2_s = R2[idx];
    if (dec) begin
      x1_s   = x ^ c;
      y1_s   = y ^ ror32(x1_s, r2_s);
      x_next = x1_s - ror32(y1_s, r1_s);
      y_next = y1_s;
    end else begin
      x1_s   = x + ror32(y, r1_s);
      y1_s   = y ^ ror32(x1_s, r2_s);
      x_next = x1_s ^ c;
      y_next = y1_s;
    end
  end

endmodule

// File: rtl/alzette_ise_mc.sv
// Multi-cycle Alzette unit on the ise_* request bus: returns x after the full
// 4-step box and keeps y in a buffer for a later GETY request.
module alzette_ise_mc
  import alzette_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1,
  parameter bit DEC_EN          = 1'b1
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic [5:0]  ise_fn,
  input  logic [6:0]  ise_imm,
  input  logic [31:0] ise_in1,
  input  logic [31:0] ise_in2,
  input  logic        ise_val,
  output logic        ise_rdy,
  output logic        ise_oval,
  output logic [31:0] ise_out
);

  state_t      state_r;
  state_t      state_s;
  op_t         op_r;
  op_t         req_op_s;
  logic [31:0] x_r;
  logic [31:0] y_r;
  logic [31:0] c_r;
  logic [31:0] ybuf_r;
  logic [2:0]  cnt_r;
  logic        rdy_r;
  logic        oval_r;
  logic [31:0] out_r;
  logic        accept_s;
  logic        load_s;
  logic        last_s;
  logic        dec_s;
  logic [31:0] x_done_s;
  logic [31:0] y_done_s;
  logic        unused_fn_s;

  // Only the low two opcode bits take part in decode
  assign unused_fn_s = ^ise_fn[5:2];

  assign req_op_s = decode_op(ise_fn[1:0], ise_imm[6:3], DEC_EN);
  assign accept_s = ise_val && rdy_r;
  assign load_s   = accept_s && (req_op_s != OP_NONE);
  assign dec_s    = (op_r == OP_DEC);
  assign last_s   = ((cnt_r + 3'(STEPS_PER_CYCLE)) >= 3'd4);

  // Unrolled step chain; decrypt walks the step indices downward
  for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
    logic [31:0] xi_s;
    logic [31:0] yi_s;
    logic [31:0] xo_s;
    logic [31:0] yo_s;
    logic [1:0]  pos_s;
    logic [1:0]  idx_s;

    if (gi == 0) begin : g_first
      assign xi_s = x_r;
      assign yi_s = y_r;
    end else begin : g_next
      assign xi_s = g_step[gi-1].xo_s;
      assign yi_s = g_step[gi-1].yo_s;
    end

    assign pos_s = cnt_r[1:0] + 2'(gi);
    assign idx_s = dec_s ? (2'd3 - pos_s) : pos_s;

    alzette_step u_step (
      .x      (xi_s),
      .y      (yi_s),
      .c      (c_r),
      .idx    (idx_s),
      .dec    (dec_s),
      .x_next (xo_s),
      .y_next (yo_s)
    );
  end

  assign x_done_s = g_step[STEPS_PER_CYCLE-1].xo_s;
  assign y_done_s = g_step[STEPS_PER_CYCLE-1].yo_s;

  // FSM state register
  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; IDLE and RESP both accept, so they share one decision
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (accept_s) begin
          case (req_op_s)
            OP_ENC, OP_DEC: state_s = ST_BUSY;
            OP_GETY:        state_s = ST_RESP;
            default:        state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand latch, step iteration and y buffer update
  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      op_r   <= OP_NONE;
      x_r    <= 32'h0000_0000;
      y_r    <= 32'h0000_0000;
      c_r    <= 32'h0000_0000;
      ybuf_r <= 32'h0000_0000;
      cnt_r  <= 3'd0;
    end else begin
      if (state_r == ST_BUSY) begin
        x_r   <= x_done_s;
        y_r   <= y_done_s;
        cnt_r <= cnt_r + 3'(STEPS_PER_CYCLE);
      end
      // The buffer samples y before a back-to-back request overwrites it
      if ((state_r == ST_RESP) && (op_r != OP_GETY)) begin
        ybuf_r <= y_r;
      end
      if (load_s) begin
        op_r <= req_op_s;
        if (req_op_s != OP_GETY) begin
          x_r   <= ise_in1;
          y_r   <= ise_in2;
          c_r   <= RCON[ise_imm[2:0]];
          cnt_r <= 3'd0;
        end
      end
    end
  end

  // Registered handshake and result; the result word is zero outside the pulse
  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      rdy_r  <= 1'b1;
      oval_r <= 1'b0;
      out_r  <= 32'h0000_0000;
    end else begin
      rdy_r  <= (state_s != ST_BUSY);
      oval_r <= (state_r == ST_RESP);
      if (state_r == ST_RESP) begin
        out_r <= (op_r == OP_GETY) ? ybuf_r : x_r;
      end else begin
        out_r <= 32'h0000_0000;
      end
    end
  end

  assign ise_rdy  = rdy_r;
  assign ise_oval = oval_r;
  assign ise_out  = out_r;

endmodule

// File: tb/tb_alzette_ise_mc.sv
// Directed bench for alzette_ise_mc: three unroll depths plus a decrypt-less
// build, checked against an independent unrolled Alzette encryption model.
module tb_alzette_ise_mc;

  localparam logic [5:0] FN_C2 = 6'd2;
  localparam logic [5:0] FN_C1 = 6'd1;
  localparam logic [31:0] X0 = 32'h01234567;
  localparam logic [31:0] Y0 = 32'h89ABCDEF;
  localparam int LAT [0:2] = '{5, 3, 2};
  localparam logic [31:0] RC [0:7] = '{
    32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
    32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D
  };

  logic        clk;
  logic        rst;
  logic [5:0]  fn_d  [4];
  logic [6:0]  imm_d [4];
  logic [31:0] in1_d [4];
  logic [31:0] in2_d [4];
  logic        val_d [4];
  logic        rdy   [4];
  logic        oval  [4];
  logic [31:0] out   [4];

  int n_err = 0;
  int n_chk = 0;

  alzette_ise_mc #(.STEPS_PER_CYCLE(1), .DEC_EN(1'b1)) u_dut1 (
    .ise_clk(clk), .ise_rst(rst), .ise_fn(fn_d[0]), .ise_imm(imm_d[0]),
    .ise_in1(in1_d[0]), .ise_in2(in2_d[0]), .ise_val(val_d[0]),
    .ise_rdy(rdy[0]), .ise_oval(oval[0]), .ise_out(out[0]));
  alzette_ise_mc #(.STEPS_PER_CYCLE(2), .DEC_EN(1'b1)) u_dut2 (
    .ise_clk(clk), .ise_rst(rst), .ise_fn(fn_d[1]), .ise_imm(imm_d[1]),
    .ise_in1(in1_d[1]), .ise_in2(in2_d[1]), .ise_val(val_d[1]),
    .ise_rdy(rdy[1]), .ise_oval(oval[1]), .ise_out(out[1]));
  alzette_ise_mc #(.STEPS_PER_CYCLE(4), .DEC_EN(1'b1)) u_dut4 (
    .ise_clk(clk), .ise_rst(rst), .ise_fn(fn_d[2]), .ise_imm(imm_d[2]),
    .ise_in1(in1_d[2]), .ise_in2(in2_d[2]), .ise_val(val_d[2]),
    .ise_rdy(rdy[2]), .ise_oval(oval[2]), .ise_out(out[2]));
  alzette_ise_mc #(.STEPS_PER_CYCLE(1), .DEC_EN(1'b0)) u_dut_nodec (
    .ise_clk(clk), .ise_rst(rst), .ise_fn(fn_d[3]), .ise_imm(imm_d[3]),
    .ise_in1(in1_d[3]), .ise_in2(in2_d[3]), .ise_val(val_d[3]),
    .ise_rdy(rdy[3]), .ise_oval(oval[3]), .ise_out(out[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  // Reference Alzette encryption written out step by step; returns {x, y}
  function automatic logic [63:0] ref_enc(input logic [31:0] xi, input logic [31:0] yi,
                                          input logic [31:0] c);
    logic [31:0] x;
    logic [31:0] y;
    x = xi;
    y = yi;
    x = x + rr(y, 31); y = y ^ rr(x, 24); x = x ^ c;
    x = x + rr(y, 17); y = y ^ rr(x, 17); x = x ^ c;
    x = x + y;         y = y ^ rr(x, 31); x = x ^ c;
    x = x + rr(y, 24); y = y ^ rr(x, 16); x = x ^ c;
    return {x, y};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic [5:0] fn, input logic [6:0] imm,
                       input logic [31:0] a, input logic [31:0] b);
    fn_d[k]  = fn;
    imm_d[k] = imm;
    in1_d[k] = a;
    in2_d[k] = b;
    val_d[k] = 1'b1;
  endtask

  // Issue one request, wait for its pulse; lat counts edges after the accept edge
  task automatic run_op(input int k, input logic [5:0] fn, input logic [6:0] imm,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int busy);
    int w;
    drive(k, fn, imm, a, b);
    w = 0;
    while (!rdy[k] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    val_d[k] = 1'b0;
    lat  = 0;
    busy = 0;
    while (!oval[k] && lat < 20) begin
      if (!rdy[k]) busy++;
      @(posedge clk); #1;
      lat++;
    end
    res = out[k];
  endtask

  task automatic watch(input int k, input int n, output int pulses, output int first,
                       output logic [31:0] seen);
    pulses = 0;
    first  = 0;
    seen   = 32'h0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (oval[k]) begin
        pulses++;
        if (first == 0) first = i;
        seen = out[k];
      end
    end
  endtask

  initial begin
    int          lat;
    int          busy;
    int          pulses;
    int          first;
    logic [31:0] res;
    logic [63:0] ra;
    logic [63:0] rb;

    for (int k = 0; k < 4; k++) begin
      fn_d[k] = 6'd0; imm_d[k] = 7'd0; in1_d[k] = 32'h0; in2_d[k] = 32'h0; val_d[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rdy", 32'(rdy[0]), 32'd1);
    check("reset_oval", 32'(oval[0]), 32'd0);
    check("reset_out", out[0], 32'h0);

    run_op(0, FN_C2, 7'b1110000, 32'h0, 32'h0, lat, res, busy);
    check("gety_after_reset_lat", 32'(lat), 32'd1);
    check("gety_after_reset_val", res, 32'h0);
    @(posedge clk); #1;
    check("gety_single_pulse", 32'(oval[0]), 32'd0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        ra = ref_enc(X0, Y0, RC[i]);
        run_op(k, FN_C2, {4'b1100, 3'(i)}, X0, Y0, lat, res, busy);
        check($sformatf("enc_lat k%0d i%0d", k, i), 32'(lat), 32'(LAT[k]));
        check($sformatf("enc_busy k%0d i%0d", k, i), 32'(busy), 32'(LAT[k] - 1));
        check($sformatf("enc_x k%0d i%0d", k, i), res, ra[63:32]);
        run_op(k, FN_C2, 7'b1110000, 32'h0, 32'h0, lat, res, busy);
        check($sformatf("enc_gety k%0d i%0d", k, i), res, ra[31:0]);
        run_op(k, FN_C2, {4'b1101, 3'(i)}, ra[63:32], ra[31:0], lat, res, busy);
        check($sformatf("dec_lat k%0d i%0d", k, i), 32'(lat), 32'(LAT[k]));
        check($sformatf("dec_x k%0d i%0d", k, i), res, X0);
        run_op(k, FN_C2, 7'b1110000, 32'h0, 32'h0, lat, res, busy);
        check($sformatf("dec_gety k%0d i%0d", k, i), res, Y0);
      end
    end

    // ENC accepted in the RESP cycle of a previous ENC
    ra = ref_enc(32'hDEADBEEF, 32'h0BADF00D, RC[3]);
    rb = ref_enc(32'h13579BDF, 32'h2468ACE0, RC[5]);
    drive(0, FN_C2, 7'b1100011, 32'hDEADBEEF, 32'h0BADF00D);
    @(posedge clk); #1;
    val_d[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_rdy_in_resp", 32'(rdy[0]), 32'd1);
    check("b2b_no_early_oval", 32'(oval[0]), 32'd0);
    drive(0, FN_C2, 7'b1100101, 32'h13579BDF, 32'h2468ACE0);
    @(posedge clk); #1;
    val_d[0] = 1'b0;
    check("b2b_first_oval", 32'(oval[0]), 32'd1);
    check("b2b_first_x", out[0], ra[63:32]);
    watch(0, 8, pulses, first, res);
    check("b2b_second_pulses", 32'(pulses), 32'd1);
    check("b2b_second_lat", 32'(first), 32'd5);
    check("b2b_second_x", res, rb[63:32]);
    run_op(0, FN_C2, 7'b1110000, 32'h0, 32'h0, lat, res, busy);
    check("b2b_second_gety", res, rb[31:0]);

    // GETY accepted in the RESP cycle of an ENC sees the new y
    ra = ref_enc(32'hCAFEF00D, 32'h12345678, RC[7]);
    drive(0, FN_C2, 7'b1100111, 32'hCAFEF00D, 32'h12345678);
    @(posedge clk); #1;
    val_d[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drive(0, FN_C2, 7'b1110000, 32'h0, 32'h0);
    @(posedge clk); #1;
    val_d[0] = 1'b0;
    check("b2b_gety_enc_oval", 32'(oval[0]), 32'd1);
    check("b2b_gety_enc_x", out[0], ra[63:32]);
    @(posedge clk); #1;
    check("b2b_gety_oval", 32'(oval[0]), 32'd1);
    check("b2b_gety_y", out[0], ra[31:0]);
    @(posedge clk); #1;
    check("b2b_gety_end", 32'(oval[0]), 32'd0);
    check("b2b_gety_out_zero", out[0], 32'h0);

    // Reset in the second BUSY cycle discards the operation
    drive(0, FN_C2, 7'b1100000, X0, Y0);
    @(posedge clk); #1;
    val_d[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rdy", 32'(rdy[0]), 32'd1);
    check("midrst_oval", 32'(oval[0]), 32'd0);
    check("midrst_out", out[0], 32'h0);
    watch(0, 8, pulses, first, res);
    check("midrst_no_resp", 32'(pulses), 32'd0);
    run_op(0, FN_C2, 7'b1110000, 32'h0, 32'h0, lat, res, busy);
    check("midrst_gety", res, 32'h0);

    // Unmatched ops are swallowed without touching ybuf
    ra = ref_enc(32'h00000001, 32'hFFFFFFFF, RC[1]);
    run_op(0, FN_C2, 7'b1100001, 32'h00000001, 32'hFFFFFFFF, lat, res, busy);
    check("unm_setup_x", res, ra[63:32]);
    drive(0, FN_C1, 7'b1100001, 32'h55555555, 32'hAAAAAAAA);
    @(posedge clk); #1;
    val_d[0] = 1'b0;
    check("unm_custom1_rdy", 32'(rdy[0]), 32'd1);
    watch(0, 8, pulses, first, res);
    check("unm_custom1_no_resp", 32'(pulses), 32'd0);
    drive(0, FN_C2, 7'b1111000, 32'h55555555, 32'hAAAAAAAA);
    @(posedge clk); #1;
    val_d[0] = 1'b0;
    watch(0, 8, pulses, first, res);
    check("unm_funct_no_resp", 32'(pulses), 32'd0);
    run_op(0, FN_C2, 7'b1110000, 32'h0, 32'h0, lat, res, busy);
    check("unm_gety_kept", res, ra[31:0]);

    // Decrypt opcode on the build without decrypt
    ra = ref_enc(X0, Y0, RC[2]);
    run_op(3, FN_C2, 7'b1100010, X0, Y0, lat, res, busy);
    check("nodec_enc_lat", 32'(lat), 32'd5);
    check("nodec_enc_x", res, ra[63:32]);
    drive(3, FN_C2, 7'b1101010, ra[63:32], ra[31:0]);
    @(posedge clk); #1;
    val_d[3] = 1'b0;
    check("nodec_rdy", 32'(rdy[3]), 32'd1);
    watch(3, 8, pulses, first, res);
    check("nodec_no_resp", 32'(pulses), 32'd0);
    run_op(3, FN_C2, 7'b1110000, 32'h0, 32'h0, lat, res, busy);
    check("nodec_gety_kept", res, ra[31:0]);

    // A request raised while BUSY is ignored
    ra = ref_enc(32'h89ABCDEF, 32'h01234567, RC[6]);
    drive(0, FN_C2, 7'b1100110, 32'h89ABCDEF, 32'h01234567);
    @(posedge clk); #1;
    drive(0, FN_C2, 7'b1100000, 32'hFFFF0000, 32'h0000FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    val_d[0] = 1'b0;
    watch(0, 10, pulses, first, res);
    check("busy_val_pulses", 32'(pulses), 32'd1);
    check("busy_val_lat", 32'(first), 32'd3);
    check("busy_val_x", res, ra[63:32]);
    run_op(0, FN_C2, 7'b1110000, 32'h0, 32'h0, lat, res, busy);
    check("busy_val_gety", res, ra[31:0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
